seq_divider: RTL and testbench

//   Multi-cycle restoring divider, the inverse of the ALU's single-cycle multiply path.

---
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider.sv | 150 +++++++++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Divider request/result bundle.
//   master: drives Start, Signed, a, b; observes Busy, Done and the held results.
//   slave : the divider side.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic [3:0]       ALUFlags;
  logic             DivByZero;

  modport master (
    output Start, Signed, a, b,
    input  Busy, Done, Quotient, Remainder, ALUFlags, DivByZero
  );

  modport slave (
    input  Start, Signed, a, b,
    output Busy, Done, Quotient, Remainder, ALUFlags, DivByZero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, fixed WIDTH-cycle latency.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; discards any operation in flight
//   bus   : seq_divider_if.slave (Start/Signed/a/b in; Busy/Done/results/flags out)
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             neg_q, neg_d;
  logic             sa_q, sa_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [3:0]       flags_q, flags_d;
  logic             dbz_out_q, dbz_out_d;

  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] q_step, r_step, q_fin, r_fin;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      a_raw_q   <= '0;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rmd_q     <= '0;
      flags_q   <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      a_raw_q   <= a_raw_d;
      neg_q     <= neg_d;
      sa_q      <= sa_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      rmd_q     <= rmd_d;
      flags_q   <= flags_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  // Next-state, iteration step and result write-back.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    a_raw_d   = a_raw_q;
    neg_d     = neg_q;
    sa_d      = sa_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    quot_d    = quot_q;
    rmd_d     = rmd_q;
    flags_d   = flags_q;
    dbz_out_d = dbz_out_q;

    // r_sh carries one extra bit so the compare sees the shifted-out MSB.
    r_sh   = {rem_q, quo_q[WIDTH-1]};
    ge     = (r_sh >= {1'b0, div_q});
    r_step = ge ? (r_sh[WIDTH-1:0] - div_q) : r_sh[WIDTH-1:0];
    q_step = {quo_q[WIDTH-2:0], ge};

    // Sign fix-up gives truncating semantics; divide-by-zero overrides everything.
    q_fin = neg_q ? (-q_step) : q_step;
    r_fin = sa_q ? (-r_step) : r_step;
    if (dbz_q) begin
      q_fin = '1;
      r_fin = a_raw_q;
    end

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.Start) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH);
          rem_d   = '0;
          quo_d   = (bus.Signed && bus.a[WIDTH-1]) ? (-bus.a) : bus.a;
          div_d   = (bus.Signed && bus.b[WIDTH-1]) ? (-bus.b) : bus.b;
          a_raw_d = bus.a;
          sa_d    = bus.Signed & bus.a[WIDTH-1];
          neg_d   = bus.Signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          dbz_d   = (bus.b == '0);
          ovf_d   = bus.Signed && (bus.a == MIN_VAL) && (bus.b == '1);
        end
      end
      RUN: begin
        rem_d = r_step;
        quo_d = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          quot_d    = q_fin;
          rmd_d     = r_fin;
          flags_d   = {q_fin[WIDTH-1], (q_fin == '0), 1'b0, ovf_q & ~dbz_q};
          dbz_out_d = dbz_q;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rmd_q;
  assign bus.ALUFlags  = flags_q;
  assign bus.DivByZero = dbz_out_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table + scoreboard queue + corner sequences.
module tb_seq_divider;
  localparam int unsigned W = 32;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [3:0]   flags;
    logic         dbz;
  } vec_t;

  typedef struct {
    vec_t v;
    int   done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   busy_cnt = 0;
  exp_t sb[$];
  vec_t tbl[12];

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: Busy count, Done/Busy exclusion, scoreboard pop on Done.
  always @(negedge clk) begin
    if (reset) busy_cnt = 0;
    else begin
      if (bus.Busy) busy_cnt++;
      if (bus.Busy && bus.Done) chk("busy_done_overlap", 1, 0);
      if (bus.Done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("busy_cycles", 64'(busy_cnt), 64'(W));
          chk("quotient", 64'(bus.Quotient), 64'(e.v.q));
          chk("remainder", 64'(bus.Remainder), 64'(e.v.r));
          chk("flags", 64'(bus.ALUFlags), 64'(e.v.flags));
          chk("div_by_zero", 64'(bus.DivByZero), 64'(e.v.dbz));
        end
        busy_cnt = 0;
      end
    end
  end

  // Drive an accepted Start in the current cycle and hold it one cycle.
  task automatic issue(input vec_t v);
    exp_t e;
    bus.Start = 1'b1; bus.Signed = v.sgn; bus.a = v.a; bus.b = v.b;
    e.v = v;
    e.done_cyc = cyc + W + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.Start = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (!bus.Done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.Done) chk("done_wait_timeout", 0, 1);
  endtask

  function automatic vec_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    v.sgn = sgn; v.a = a; v.b = b; v.dbz = 1'b0;
    if (sgn) begin
      v.q = W'($signed(a) / $signed(b));
      v.r = W'($signed(a) % $signed(b));
    end else begin
      v.q = a / b;
      v.r = a % b;
    end
    v.flags = {v.q[W-1], (v.q == '0), 2'b00};
    return v;
  endfunction

  initial begin
    vec_t v;
    bus.Start = 1'b0; bus.Signed = 1'b0; bus.a = '0; bus.b = '0;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, 1'b0};
    tbl[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        4'b1000, 1'b0};
    tbl[3]  = '{1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        4'b1000, 1'b1};
    tbl[4]  = '{1'b0, 32'd6,          32'd3,        32'd2,        32'd0,        4'b0000, 1'b0};
    tbl[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        4'b1001, 1'b0};
    tbl[6]  = '{1'b0, 32'd0,          32'd9,        32'd0,        32'd0,        4'b0100, 1'b0};
    tbl[7]  = '{1'b1, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 4'b1000, 1'b1};
    tbl[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        4'b1000, 1'b0};
    tbl[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 4'b0100, 1'b0};
    tbl[10] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 4'b0000, 1'b0};
    tbl[11] = '{1'b0, 32'd7,          32'd8,        32'd0,        32'd7,        4'b0100, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(bus.Busy), 0);
    chk("reset_done", 64'(bus.Done), 0);
    chk("reset_quotient", 64'(bus.Quotient), 0);
    chk("reset_flags", 64'(bus.ALUFlags), 0);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      issue(tbl[i]);
      wait_empty(3 * W);
    end

    // Random operands checked against a behavioural model.
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i < 5) ? W'($urandom_range(1, 1000)) : W'($urandom);
      if (rb == '0) rb = 32'd3;
      if (ra == 32'h80000000) ra = 32'h7FFFFFFF;
      v = model(i[0], ra, rb);
      @(posedge clk); #1;
      issue(v);
      wait_empty(3 * W);
    end

    // Start re-pulsed during RUN is ignored; then Start on the Done cycle.
    @(posedge clk); #1;
    issue(tbl[0]);
    repeat (9) @(posedge clk);
    #1;
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.a = 32'd50; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    wait_done(3 * W);
    chk("results_held_done", 64'(bus.Quotient), 64'd14);
    issue(tbl[4]);
    wait_empty(3 * W);
    @(negedge clk);
    chk("results_held_idle", 64'(bus.Quotient), 64'd2);
    chk("idle_not_busy", 64'(bus.Busy), 0);

    // Reset in cycle 15 of an operation.
    @(posedge clk); #1;
    issue(tbl[1]);
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_busy", 64'(bus.Busy), 0);
    chk("midreset_done", 64'(bus.Done), 0);
    chk("midreset_quotient", 64'(bus.Quotient), 0);
    chk("midreset_remainder", 64'(bus.Remainder), 0);
    chk("midreset_flags", 64'(bus.ALUFlags), 0);
    chk("midreset_dbz", 64'(bus.DivByZero), 0);
    repeat (W + 5) @(posedge clk);
    #1;
    issue(tbl[2]);
    wait_empty(3 * W);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
